// File: rtl/snake_frame_sequencer.sv
// Per-tick draw-command sequencer: tick divider, then head/tail/score/prey commands to the drawer.
// Latency: cmd_vld one cycle after tick; backpressure: cmd held while cmd_vld & ~cmd_rdy. Option: SNAKE_SEQ_LEADING_ZERO_BLANK_EN.
module snake_frame_sequencer #(
    parameter int         H_LOGIC_WIDTH  = 5,
    parameter int         V_LOGIC_WIDTH  = 5,
    parameter int         NUM_DIGITS     = 4,
    parameter int         LEVEL_WIDTH    = 3,
    parameter int         TICK_CNT_WIDTH = 25,
    parameter int         TICK_BASE_MAX  = 24999999,
    parameter logic [9:0] DIGIT_POSX0    = 10'd619,
    parameter logic [9:0] DIGIT_STEP     = 10'd20,
    parameter logic [8:0] DIGIT_POSY     = 9'd450,
    parameter logic [7:0] HEAD_COLOR     = 8'h0f,
    parameter logic [7:0] TAIL_COLOR     = 8'hff,
    parameter logic [7:0] PREY_COLOR     = 8'h3c
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enb,
    input  logic [LEVEL_WIDTH-1:0]    level,
    input  logic [H_LOGIC_WIDTH-1:0]  headx,
    input  logic [V_LOGIC_WIDTH-1:0]  heady,
    input  logic [H_LOGIC_WIDTH-1:0]  tailx,
    input  logic [V_LOGIC_WIDTH-1:0]  taily,
    input  logic [H_LOGIC_WIDTH-1:0]  preyx,
    input  logic [V_LOGIC_WIDTH-1:0]  preyy,
    input  logic                      prey_upd,
    input  logic [4*NUM_DIGITS-1:0]   score_bcd,
    input  logic                      lose,
    output logic                      tick,
    output logic [31:0]               cmd,
    output logic                      cmd_vld,
    input  logic                      cmd_rdy,
    output logic                      busy,
    output logic                      overrun
);

    typedef enum logic [2:0] {S_IDLE, S_HEAD, S_TAIL, S_DIGA, S_DIGB, S_PREY} state_t;

    localparam logic [TICK_CNT_WIDTH-1:0] BASE     = TICK_CNT_WIDTH'(TICK_BASE_MAX);
    localparam logic [31:0]               CHAR_B   = {4'ha, 8'h00, 8'hff, 4'h1, 8'h01};
    localparam logic [2:0]                LAST_DIG = 3'(NUM_DIGITS - 1);

    state_t                        state_q;
    logic [2:0]                    dig_q;
    logic [31:0]                   cmd_q;
    logic                          cmd_vld_q;
    logic                          prey_pend_q;
    logic                          overrun_q;
    logic [H_LOGIC_WIDTH-1:0]      prey_x_q, tail_x_q;
    logic [V_LOGIC_WIDTH-1:0]      prey_y_q, tail_y_q;
    logic [4*NUM_DIGITS-1:0]       score_q;
    logic [TICK_CNT_WIDTH-1:0]     cnt_q, cnt_d, reload;
    logic                          hs;

    function automatic logic [31:0] cell_cmd(input logic [4:0] x, input logic [4:0] y,
                                             input logic [7:0] colour);
        return {4'h0, x, y, colour, 10'd0};
    endfunction

    function automatic logic [7:0] digit_ascii(input logic [4*NUM_DIGITS-1:0] bcd,
                                               input logic [2:0] idx);
        logic [3:0] nib;
        logic       blank;
        nib   = bcd[4*int'(idx) +: 4];
        blank = 1'b0;
`ifdef SNAKE_SEQ_LEADING_ZERO_BLANK_EN
        if (idx != 3'd0) begin
            blank = 1'b1;
            for (int j = 0; j < NUM_DIGITS; j++)
                if (j >= int'(idx) && bcd[4*j +: 4] != 4'd0) blank = 1'b0;
        end
`endif
        if (blank) return 8'h20;
        if (nib > 4'd9) return 8'h3f;
        return 8'h30 + {4'h0, nib};
    endfunction

    function automatic logic [31:0] char_a(input logic [4*NUM_DIGITS-1:0] bcd, input logic [2:0] idx);
        logic [9:0] posx;
        posx = DIGIT_POSX0 - 10'(idx) * DIGIT_STEP;
        return {4'ha, posx, DIGIT_POSY, digit_ascii(bcd, idx), 1'b0};
    endfunction

    // Tick is combinational so the first one lands in the first enabled cycle after reset.
    assign reload = BASE >> level;
    assign tick   = rst_n & enb & ~lose & (cnt_q == '0);
    assign hs     = cmd_vld_q & cmd_rdy;

    always_comb begin
        cnt_d = cnt_q;
        if (lose)
            cnt_d = reload;
        else if (enb)
            cnt_d = (cnt_q == '0) ? reload : cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    // The registered HEAD command itself serves as the head snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            dig_q       <= '0;
            cmd_q       <= '0;
            cmd_vld_q   <= 1'b0;
            prey_pend_q <= 1'b0;
            overrun_q   <= 1'b0;
            prey_x_q    <= '0;
            prey_y_q    <= '0;
            tail_x_q    <= '0;
            tail_y_q    <= '0;
            score_q     <= '0;
        end else begin
            if (prey_upd) begin
                prey_x_q <= preyx;
                prey_y_q <= preyy;
            end
            if (lose) begin
                state_q     <= S_IDLE;
                cmd_vld_q   <= 1'b0;
                prey_pend_q <= 1'b0;
            end else begin
                if (tick && state_q != S_IDLE) overrun_q <= 1'b1;
                if (prey_upd)                         prey_pend_q <= 1'b1;
                else if (state_q == S_PREY && hs)     prey_pend_q <= 1'b0;
                case (state_q)
                    S_IDLE: begin
                        if (tick) begin
                            tail_x_q  <= tailx;
                            tail_y_q  <= taily;
                            score_q   <= score_bcd;
                            cmd_q     <= cell_cmd(5'(headx), 5'(heady), HEAD_COLOR);
                            cmd_vld_q <= 1'b1;
                            state_q   <= S_HEAD;
                        end else if (prey_pend_q && enb) begin
                            cmd_q     <= cell_cmd(5'(prey_x_q), 5'(prey_y_q), PREY_COLOR);
                            cmd_vld_q <= 1'b1;
                            state_q   <= S_PREY;
                        end
                    end
                    S_HEAD: if (hs) begin
                        cmd_q   <= cell_cmd(5'(tail_x_q), 5'(tail_y_q), TAIL_COLOR);
                        state_q <= S_TAIL;
                    end
                    S_TAIL: if (hs) begin
                        dig_q   <= 3'd0;
                        cmd_q   <= char_a(score_q, 3'd0);
                        state_q <= S_DIGA;
                    end
                    S_DIGA: if (hs) begin
                        cmd_q   <= CHAR_B;
                        state_q <= S_DIGB;
                    end
                    S_DIGB: if (hs) begin
                        if (dig_q != LAST_DIG) begin
                            dig_q   <= dig_q + 3'd1;
                            cmd_q   <= char_a(score_q, dig_q + 3'd1);
                            state_q <= S_DIGA;
                        end else if (prey_pend_q) begin
                            cmd_q   <= cell_cmd(5'(prey_x_q), 5'(prey_y_q), PREY_COLOR);
                            state_q <= S_PREY;
                        end else begin
                            cmd_vld_q <= 1'b0;
                            state_q   <= S_IDLE;
                        end
                    end
                    S_PREY: if (hs) begin
                        cmd_vld_q <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                    default: begin
                        cmd_vld_q <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign cmd     = cmd_q;
    assign cmd_vld = cmd_vld_q;
    assign busy    = (state_q != S_IDLE);
    assign overrun = overrun_q;

endmodule
